alu_mul_sequencer: RTL
======================

# alu_mul_sequencer

Multi-cycle 16x16 multiplier controller that owns the 32-bit ALU's FunSel and operand inputs. It computes products by shift-and-add, issuing ALU add, shift and subtract operations. It sits between the control unit (start/done handshake) and the ALU, and is the only driver of the ALU while instantiated. ALU flags are not consumed; all decisions use sequencer-local state.

## Interface
- ALU_LAT, 1: cycles from the ALU sampling edge until ALUOut is stable and captured by the sequencer (must be >= 1).
- clock  in  1  rising-edge system clock, shared with the ALU
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- op_a  in  16  multiplicand; sampled with start
- op_b  in  16  multiplier; sampled with start
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; product valid
- product  out  32  last result, held until the next DONE
- alu_funsel  out  5  ALU FunSel
- alu_a  out  32  ALU input_a
- alu_b  out  32  ALU input_b
- alu_out  in  32  ALU ALUOut

## Operation
- Reset (async, immediate): state=IDLE; busy=0, done=0, product=0; alu_funsel=5'b10000, alu_a=0, alu_b=0; internal acc, mcand, mplier, count and neg cleared.
- IDLE: ALU outputs are held at their reset values. When start=1 at a rising edge:
  - unsigned: mcand={16'b0,op_a}, mplier=op_b, neg=0;
  - signed: mcand = zero-extended |op_a|, mplier = |op_b| as 16-bit unsigned (0x8000 magnitude is exact), neg = op_a[15]^op_b[15];
  - acc=0, count=0; then go to TEST.
- TEST: if mplier[0]=1, go to ADD_X; otherwise go to SHL_X.
- ADD_X: drive funsel=5'b10100, a=acc, b=mcand. Go to ADD_W.
- ADD_W: hold for ALU_LAT cycles; capture acc=alu_out on the last edge. Go to SHL_X.
- SHL_X: drive funsel=5'b11011, a=mcand, b=0. Go to SHL_W.
- SHL_W: hold ALU_LAT cycles; on the last edge capture mcand=alu_out, mplier=mplier>>1, count=count+1.
  - If count was 15: go to NEG_X when neg=1, else DONE.
  - Otherwise go to TEST.
- NEG_X: drive funsel=5'b10110, a=0, b=acc. Go to NEG_W.
- NEG_W: hold ALU_LAT cycles; capture acc=alu_out. Go to DONE.
- DONE: product=acc (registered on entry, so it is visible during DONE); done=1; busy=1. Go to IDLE.
- ALU outputs are registered and stay stable for the whole X+W window of each operation. Outside an operation they return to pass-A / zero.
- Arithmetic is modulo 2^32. Each shifted mcand fits in 32 bits because its bit count is at most 16+15. A signed product of -32768 x -32768 gives 0x40000000 with neg=0.
- start while busy=1 is ignored and not queued. start in the DONE cycle is ignored. op_* changes after acceptance have no effect.

## Timing
- Let edge E0 accept start. Cycle k is the k-th cycle after E0.
- Per multiplier bit: 1 (TEST) + (1+ALU_LAT) (SHL) + (1+ALU_LAT)*bit (ADD).
- With ALU_LAT=1: done=1 in cycle 49 + 2*popcount(|op_b|) + 2*neg. Examples:
  - op_b=0, unsigned: cycle 49;
  - op_b=0xFFFF, unsigned: cycle 81.
- busy rises in cycle 1 and falls after the DONE cycle. The earliest next acceptance is the edge at the end of the first IDLE cycle after DONE.
- product changes only at the DONE entry edge.
- Reset asserted mid-operation aborts the operation. product returns to 0 and done is never pulsed for the aborted request.

## Test plan
- Unsigned 3 x 5: product=0x0000000F, done in cycle 53. FunSel trace: TEST, ADD, SHL, TEST, SHL, TEST, ADD, SHL, then SHL only.
- Unsigned 0xFFFF x 0xFFFF: product=0xFFFE0001, done in cycle 81; busy high in cycles 1..81.
- Signed -3 x 5 (op_a=0xFFFD): product=0xFFFFFFF1. A NEG op (funsel 10110, a=0) precedes DONE; done in cycle 55.
- Signed 0x8000 x 0x8000: product=0x40000000, no NEG op; done in cycle 51.
- start pulsed in cycles 10 and (done cycle) with new operands: the first result is unchanged and no second operation starts. A start in the following IDLE cycle is accepted.
- reset_n low in cycle 20 of 7 x 9: all outputs are at reset values immediately and done is never seen. A new 7 x 9 after release gives 0x0000003F.

Source files
------------

// File: rtl/alu_mul_sequencer_if.sv
// Control-unit request/result handshake plus the ALU operand/result bus.
// Pure wiring; no latency.
// No backpressure: start is level-sampled only when the sequencer is idle.
interface alu_mul_sequencer_if;
    logic        start;
    logic        op_signed;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [4:0]  alu_funsel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;

    modport master (
        output start, op_signed, op_a, op_b, alu_out,
        input  busy, done, product, alu_funsel, alu_a, alu_b
    );

    modport slave (
        input  start, op_signed, op_a, op_b, alu_out,
        output busy, done, product, alu_funsel, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// 16x16 shift-and-add multiplier driving an external 32-bit ALU.
// Latency: 49 + 2*popcount(|op_b|) + 2*neg cycles at ALU_LAT=1.
// No backpressure: start is ignored unless idle; done is a single-cycle pulse.
module alu_mul_sequencer #(
    parameter int ALU_LAT = 1
) (
    input logic                 clock,
    input logic                 reset_n,
    alu_mul_sequencer_if.slave  bus
);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] TEST  = 4'd1;
    localparam logic [3:0] ADD_X = 4'd2;
    localparam logic [3:0] ADD_W = 4'd3;
    localparam logic [3:0] SHL_X = 4'd4;
    localparam logic [3:0] SHL_W = 4'd5;
    localparam logic [3:0] NEG_X = 4'd6;
    localparam logic [3:0] NEG_W = 4'd7;
    localparam logic [3:0] DONE  = 4'd8;

    localparam logic [4:0] FS_PASS = 5'b10000;
    localparam logic [4:0] FS_ADD  = 5'b10100;
    localparam logic [4:0] FS_SUB  = 5'b10110;
    localparam logic [4:0] FS_SHL  = 5'b11011;

    logic [3:0]    state, next_state;
    logic [31:0]   acc, mcand;
    logic [15:0]   mplier;
    logic [3:0]    count;
    logic          neg;
    logic [LW-1:0] lat_cnt;
    logic          lat_last;
    logic          in_wait;
    logic [4:0]    funsel_n;
    logic [31:0]   a_n, b_n;
    logic [15:0]   mag_a, mag_b;

    assign lat_last = (lat_cnt == LW'(ALU_LAT - 1));
    assign in_wait  = (state == ADD_W) || (state == SHL_W) || (state == NEG_W);
    // 0x8000 negates to itself, which is the exact unsigned magnitude
    assign mag_a = (bus.op_signed && bus.op_a[15]) ? (~bus.op_a + 16'd1) : bus.op_a;
    assign mag_b = (bus.op_signed && bus.op_b[15]) ? (~bus.op_b + 16'd1) : bus.op_b;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = TEST;
            TEST:    next_state = mplier[0] ? ADD_X : SHL_X;
            ADD_X:   next_state = ADD_W;
            ADD_W:   if (lat_last) next_state = SHL_X;
            SHL_X:   next_state = SHL_W;
            SHL_W:   if (lat_last) begin
                         if (count == 4'd15) next_state = neg ? NEG_X : DONE;
                         else                next_state = TEST;
                     end
            NEG_X:   next_state = NEG_W;
            NEG_W:   if (lat_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ALU operands are a function of the state being entered, so they are
    // already registered and stable for the whole X+W window of each op.
    always_comb begin
        funsel_n = FS_PASS;
        a_n      = 32'd0;
        b_n      = 32'd0;
        case (next_state)
            ADD_X, ADD_W: begin funsel_n = FS_ADD; a_n = acc;   b_n = mcand; end
            SHL_X, SHL_W: begin funsel_n = FS_SHL; a_n = mcand; b_n = 32'd0; end
            NEG_X, NEG_W: begin funsel_n = FS_SUB; a_n = 32'd0; b_n = acc;   end
            default:      ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            acc            <= 32'd0;
            mcand          <= 32'd0;
            mplier         <= 16'd0;
            count          <= 4'd0;
            neg            <= 1'b0;
            lat_cnt        <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.product    <= 32'd0;
            bus.alu_funsel <= FS_PASS;
            bus.alu_a      <= 32'd0;
            bus.alu_b      <= 32'd0;
        end else begin
            state          <= next_state;
            bus.alu_funsel <= funsel_n;
            bus.alu_a      <= a_n;
            bus.alu_b      <= b_n;
            bus.busy       <= (next_state != IDLE);
            bus.done       <= (next_state == DONE);

            if (in_wait) lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;

            // Coming from NEG_W the final acc is still on the ALU output
            if (next_state == DONE)
                bus.product <= (state == NEG_W) ? bus.alu_out : acc;

            case (state)
                IDLE: if (bus.start) begin
                    mcand  <= {16'd0, mag_a};
                    mplier <= mag_b;
                    neg    <= bus.op_signed & (bus.op_a[15] ^ bus.op_b[15]);
                    acc    <= 32'd0;
                    count  <= 4'd0;
                end
                ADD_W: if (lat_last) acc <= bus.alu_out;
                SHL_W: if (lat_last) begin
                    mcand  <= bus.alu_out;
                    mplier <= mplier >> 1;
                    count  <= count + 4'd1;
                end
                NEG_W: if (lat_last) acc <= bus.alu_out;
                default: ;
            endcase
        end
    end
endmodule
